// File: rtl/data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : data_mem_responder
// Brief    : Single-port word-organised data memory behind a valid/ready
//            request/response handshake. Supports byte, halfword and word
//            loads (signed/unsigned) and stores, rejecting malformed requests.
// Revision : 1.0 - initial release
// ============================================================================
module data_mem_responder #(
    parameter int DEPTH = 1024,
    parameter int AW    = 10
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        REQ_VALID,
    output logic        REQ_READY,
    input  logic        MEM_READ,
    input  logic        MEM_WRITE,
    input  logic [31:0] ADDR,
    input  logic [31:0] WDATA,
    input  logic [2:0]  FUNCT3,
    output logic        RSP_VALID,
    input  logic        RSP_READY,
    output logic [31:0] RDATA,
    output logic        ERROR
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACCESS  = 2'd1,
        ST_RESPOND = 2'd2
    } state_t;

    state_t        state_q;
    state_t        state_d;

    // Request fields captured at acceptance; they stay frozen for the whole
    // transaction so later input activity cannot disturb it.
    logic [31:0]   addr_q;
    logic [31:0]   wdata_q;
    logic [2:0]    funct3_q;
    logic          rd_q;
    logic          wr_q;

    logic [31:0]   rdata_q;
    logic [31:0]   rdata_d;
    logic          err_q;
    logic          err_d;

    logic [31:0]   mem_q [DEPTH];

    logic          w_accept;
    logic          w_f3_bad;
    logic          w_misalign;
    logic          w_oor;
    logic          w_err;
    logic [AW-1:0] w_idx;
    logic [1:0]    w_lane;
    logic [31:0]   w_word;
    logic [31:0]   w_byte_sh;
    logic [31:0]   w_half_sh;
    logic [31:0]   w_load;
    logic [3:0]    w_be;
    logic [31:0]   w_wrep;
    logic          w_we;

    assign w_accept = REQ_VALID && (state_q == ST_IDLE);

    // FSM next state and handshake outputs
    always_comb begin
        state_d   = state_q;
        REQ_READY = 1'b0;
        RSP_VALID = 1'b0;
        case (state_q)
            ST_IDLE: begin
                REQ_READY = 1'b1;
                if (REQ_VALID) begin
                    state_d = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                state_d = ST_RESPOND;
            end
            ST_RESPOND: begin
                RSP_VALID = 1'b1;
                if (RSP_READY) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM state register
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Capture the request on acceptance; reset wins over a simultaneous accept
    always_ff @(posedge CLK) begin
        if (RST) begin
            addr_q   <= '0;
            wdata_q  <= '0;
            funct3_q <= '0;
            rd_q     <= 1'b0;
            wr_q     <= 1'b0;
        end else if (w_accept) begin
            addr_q   <= ADDR;
            wdata_q  <= WDATA;
            funct3_q <= FUNCT3;
            rd_q     <= MEM_READ;
            wr_q     <= MEM_WRITE;
        end
    end

    // Request decode: legality checks, addressing, load extraction, store lanes
    always_comb begin
        w_f3_bad   = (funct3_q == 3'b011) || (funct3_q == 3'b110) ||
                     (funct3_q == 3'b111);
        w_misalign = ((funct3_q[1:0] == 2'b01) && addr_q[0]) ||
                     ((funct3_q[1:0] == 2'b10) && (addr_q[1:0] != 2'b00));
        w_oor      = ({2'b00, addr_q[31:2]} >= 32'(DEPTH));
        // A request with neither read nor write never faults
        w_err      = (rd_q || wr_q) && (w_f3_bad || w_misalign || w_oor);
        w_idx      = addr_q[AW+1:2];
        w_lane     = addr_q[1:0];
        w_word     = w_oor ? 32'd0 : mem_q[w_idx];
        w_byte_sh  = w_word >> {w_lane, 3'b000};
        w_half_sh  = w_word >> {w_lane[1], 4'b0000};

        case (funct3_q)
            3'b000:  w_load = {{24{w_byte_sh[7]}}, w_byte_sh[7:0]};
            3'b100:  w_load = {24'd0, w_byte_sh[7:0]};
            3'b001:  w_load = {{16{w_half_sh[15]}}, w_half_sh[15:0]};
            3'b101:  w_load = {16'd0, w_half_sh[15:0]};
            3'b010:  w_load = w_word;
            default: w_load = 32'd0;
        endcase

        // Store data is replicated across lanes; byte enables pick the target
        case (funct3_q[1:0])
            2'b00:   w_be = 4'b0001 << w_lane;
            2'b01:   w_be = 4'b0011 << {w_lane[1], 1'b0};
            2'b10:   w_be = 4'b1111;
            default: w_be = 4'b0000;
        endcase
        case (funct3_q[1:0])
            2'b00:   w_wrep = {4{wdata_q[7:0]}};
            2'b01:   w_wrep = {2{wdata_q[15:0]}};
            default: w_wrep = wdata_q;
        endcase

        // Write takes precedence over read; a reset on this edge cancels it
        w_we    = (state_q == ST_ACCESS) && wr_q && !w_err && !RST;
        rdata_d = (rd_q && !wr_q && !w_err) ? w_load : 32'd0;
        err_d   = w_err;
    end

    // Data array update on the edge that leaves ACCESS; contents are never reset
    always_ff @(posedge CLK) begin
        for (int i = 0; i < 4; i++) begin
            if (w_we && w_be[i]) begin
                mem_q[w_idx][8*i +: 8] <= w_wrep[8*i +: 8];
            end
        end
    end

    // Response registers: loaded when leaving ACCESS, cleared once consumed
    always_ff @(posedge CLK) begin
        if (RST) begin
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else if (state_q == ST_ACCESS) begin
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end else if ((state_q == ST_RESPOND) && RSP_READY) begin
            rdata_q <= '0;
            err_q   <= 1'b0;
        end
    end

    assign RDATA = rdata_q;
    assign ERROR = err_q;

endmodule
`default_nettype wire

// File: tb/tb_data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_data_mem_responder
// Brief    : Self-checking bench for data_mem_responder: directed vector table,
//            hand-written handshake/reset sequences and random traffic checked
//            against a behavioural memory model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_data_mem_responder;

    localparam int DEPTH = 1024;
    localparam int AW    = 10;

    logic        CLK = 1'b0;
    logic        RST;
    logic        REQ_VALID;
    logic        REQ_READY;
    logic        MEM_READ;
    logic        MEM_WRITE;
    logic [31:0] ADDR;
    logic [31:0] WDATA;
    logic [2:0]  FUNCT3;
    logic        RSP_VALID;
    logic        RSP_READY;
    logic [31:0] RDATA;
    logic        ERROR;

    int n_checks = 0;
    int n_fail   = 0;

    bit [31:0] mdl [DEPTH];

    typedef struct {
        bit        rd;
        bit        wr;
        bit [2:0]  f3;
        bit [31:0] addr;
        bit [31:0] wdata;
        bit [31:0] exp_rdata;
        bit        exp_err;
    } vec_t;

    vec_t tbl [17];

    data_mem_responder #(.DEPTH(DEPTH), .AW(AW)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .REQ_VALID (REQ_VALID),
        .REQ_READY (REQ_READY),
        .MEM_READ  (MEM_READ),
        .MEM_WRITE (MEM_WRITE),
        .ADDR      (ADDR),
        .WDATA     (WDATA),
        .FUNCT3    (FUNCT3),
        .RSP_VALID (RSP_VALID),
        .RSP_READY (RSP_READY),
        .RDATA     (RDATA),
        .ERROR     (ERROR)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Behavioural reference: memory as an array of words, lanes by arithmetic
    function automatic void model(input bit rd, input bit wr, input bit [2:0] f3,
                                  input bit [31:0] a, input bit [31:0] wd,
                                  output bit [31:0] r, output bit e);
        int unsigned widx = a / 4;
        int unsigned lane = a % 4;
        bit [31:0]   w;
        bit [31:0]   mask;
        r = 0;
        e = 0;
        if (!rd && !wr) return;
        if (f3 == 3 || f3 == 6 || f3 == 7)           e = 1;
        if ((f3 == 1 || f3 == 5) && (a % 2 != 0))     e = 1;
        if (f3 == 2 && lane != 0)                     e = 1;
        if (widx >= DEPTH)                            e = 1;
        if (e) return;
        w = mdl[widx];
        if (wr) begin
            case (f3)
                0: begin
                    mask = 32'hFF << (8 * lane);
                    w = (w & ~mask) | ((wd & 32'hFF) << (8 * lane));
                end
                1: begin
                    mask = 32'hFFFF << (8 * lane);
                    w = (w & ~mask) | ((wd & 32'hFFFF) << (8 * lane));
                end
                default: w = wd;
            endcase
            mdl[widx] = w;
        end else begin
            case (f3)
                0: begin
                    r = (w >> (8 * lane)) & 32'hFF;
                    if (r >= 128) r = r - 256;
                end
                4: r = (w >> (8 * lane)) & 32'hFF;
                1: begin
                    r = (w >> (8 * lane)) & 32'hFFFF;
                    if (r >= 32768) r = r - 65536;
                end
                5: r = (w >> (8 * lane)) & 32'hFFFF;
                default: r = w;
            endcase
        end
    endfunction

    // One full transaction; inputs are scrambled after acceptance
    task automatic txn(input bit rd, input bit wr, input bit [2:0] f3,
                       input bit [31:0] a, input bit [31:0] wd, input int stall,
                       output bit [31:0] r, output bit e, output int lat);
        int n = 0;
        @(negedge CLK);
        while (!REQ_READY && n < 20) begin
            @(negedge CLK);
            n++;
        end
        if (!REQ_READY) chk("ready_timeout", REQ_READY, 1'b1);
        MEM_READ  = rd;
        MEM_WRITE = wr;
        FUNCT3    = f3;
        ADDR      = a;
        WDATA     = wd;
        REQ_VALID = 1'b1;
        RSP_READY = (stall == 0);
        @(posedge CLK);
        #1;
        REQ_VALID = 1'b0;
        ADDR      = $urandom;
        WDATA     = $urandom;
        FUNCT3    = 3'($urandom);
        MEM_READ  = 1'($urandom);
        MEM_WRITE = 1'($urandom);
        lat = 1;
        while (!RSP_VALID && lat < 10) begin
            @(posedge CLK);
            #1;
            lat++;
        end
        r = RDATA;
        e = ERROR;
        if (stall > 0) begin
            repeat (stall) @(negedge CLK);
            chk("stall_rdata", RDATA, r);
            RSP_READY = 1'b1;
        end
        @(posedge CLK);
        #1;
    endtask

    initial begin
        bit [31:0] r;
        bit [31:0] mr;
        bit        e;
        bit        me;
        int        lat;
        int        n;
        bit        rd;
        bit        wr;
        bit [2:0]  f3;
        bit [31:0] a;
        bit [31:0] wd;

        tbl[0]  = '{0, 1, 3'b010, 32'h10,   32'hDEADBEEF, 32'h0,        0};
        tbl[1]  = '{1, 0, 3'b010, 32'h10,   32'h0,        32'hDEADBEEF, 0};
        tbl[2]  = '{0, 1, 3'b000, 32'h11,   32'h00000080, 32'h0,        0};
        tbl[3]  = '{1, 0, 3'b000, 32'h11,   32'h0,        32'hFFFFFF80, 0};
        tbl[4]  = '{1, 0, 3'b100, 32'h11,   32'h0,        32'h00000080, 0};
        tbl[5]  = '{1, 0, 3'b010, 32'h10,   32'h0,        32'hDEAD80EF, 0};
        tbl[6]  = '{1, 0, 3'b001, 32'h13,   32'h0,        32'h0,        1};
        tbl[7]  = '{0, 1, 3'b010, 32'h12,   32'h11111111, 32'h0,        1};
        tbl[8]  = '{1, 0, 3'b010, 32'h10,   32'h0,        32'hDEAD80EF, 0};
        tbl[9]  = '{1, 1, 3'b010, 32'h20,   32'h12345678, 32'h0,        0};
        tbl[10] = '{1, 0, 3'b010, 32'h20,   32'h0,        32'h12345678, 0};
        tbl[11] = '{0, 0, 3'b111, 32'h13,   32'h0,        32'h0,        0};
        tbl[12] = '{1, 0, 3'b001, 32'h10,   32'h0,        32'hFFFF80EF, 0};
        tbl[13] = '{1, 0, 3'b101, 32'h12,   32'h0,        32'h0000DEAD, 0};
        tbl[14] = '{1, 0, 3'b010, 32'h1000, 32'h0,        32'h0,        1};
        tbl[15] = '{0, 1, 3'b000, 32'h1003, 32'h5A,       32'h0,        1};
        tbl[16] = '{1, 0, 3'b011, 32'h10,   32'h0,        32'h0,        1};

        RST       = 1'b1;
        REQ_VALID = 1'b0;
        MEM_READ  = 1'b0;
        MEM_WRITE = 1'b0;
        ADDR      = '0;
        WDATA     = '0;
        FUNCT3    = '0;
        RSP_READY = 1'b1;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        chk("reset_req_ready", REQ_READY, 1'b1);
        chk("reset_rsp_valid", RSP_VALID, 1'b0);
        chk("reset_rdata", RDATA, 32'h0);
        chk("reset_error", ERROR, 1'b0);

        // Give the window of words used below known contents
        for (int w = 0; w < 16; w++) begin
            wd = $urandom;
            model(0, 1, 3'b010, 32'(w * 4), wd, mr, me);
            txn(0, 1, 3'b010, 32'(w * 4), wd, 0, r, e, lat);
        end

        // Directed vector table
        for (int i = 0; i < 17; i++) begin
            model(tbl[i].rd, tbl[i].wr, tbl[i].f3, tbl[i].addr, tbl[i].wdata, mr, me);
            txn(tbl[i].rd, tbl[i].wr, tbl[i].f3, tbl[i].addr, tbl[i].wdata, 0, r, e, lat);
            chk($sformatf("tbl%0d_rdata", i), r, tbl[i].exp_rdata);
            chk($sformatf("tbl%0d_error", i), e, tbl[i].exp_err);
            chk($sformatf("tbl%0d_latency", i), lat, 2);
        end

        // Response held for 5 cycles while another request is presented
        @(negedge CLK);
        n = 0;
        while (!REQ_READY && n < 20) begin
            @(negedge CLK);
            n++;
        end
        MEM_READ  = 1'b1;
        MEM_WRITE = 1'b0;
        FUNCT3    = 3'b010;
        ADDR      = 32'h10;
        REQ_VALID = 1'b1;
        RSP_READY = 1'b0;
        @(posedge CLK);
        #1;
        ADDR      = 32'h20;
        MEM_WRITE = 1'b1;
        n = 1;
        while (!RSP_VALID && n < 10) begin
            @(posedge CLK);
            #1;
            n++;
        end
        chk("stall_latency", n, 2);
        r = RDATA;
        chk("stall_first_rdata", r, 32'hDEAD80EF);
        for (int k = 0; k < 5; k++) begin
            @(negedge CLK);
            chk("stall_rsp_valid", RSP_VALID, 1'b1);
            chk("stall_rdata_stable", RDATA, r);
            chk("stall_error_stable", ERROR, 1'b0);
            chk("stall_req_ready", REQ_READY, 1'b0);
        end
        REQ_VALID = 1'b0;
        RSP_READY = 1'b1;
        @(posedge CLK);
        #1;
        chk("release_req_ready", REQ_READY, 1'b1);
        chk("release_rsp_valid", RSP_VALID, 1'b0);
        repeat (2) begin
            @(posedge CLK);
            #1;
            chk("no_late_accept", RSP_VALID, 1'b0);
        end
        model(1, 0, 3'b010, 32'h20, 0, mr, me);
        txn(1, 0, 3'b010, 32'h20, 0, 0, r, e, lat);
        chk("stall_no_write", r, mr);

        // Reset during ACCESS of a store cancels it
        @(negedge CLK);
        MEM_READ  = 1'b0;
        MEM_WRITE = 1'b1;
        FUNCT3    = 3'b010;
        ADDR      = 32'h30;
        WDATA     = 32'hFFFFFFFF;
        REQ_VALID = 1'b1;
        @(posedge CLK);
        #1;
        REQ_VALID = 1'b0;
        RST       = 1'b1;
        @(posedge CLK);
        #1;
        RST = 1'b0;
        chk("rst_access_req_ready", REQ_READY, 1'b1);
        chk("rst_access_rsp_valid", RSP_VALID, 1'b0);
        chk("rst_access_rdata", RDATA, 32'h0);
        chk("rst_access_error", ERROR, 1'b0);
        model(1, 0, 3'b010, 32'h30, 0, mr, me);
        txn(1, 0, 3'b010, 32'h30, 0, 0, r, e, lat);
        chk("rst_access_prior_value", r, mr);

        // Reset coincident with acceptance drops the request
        @(negedge CLK);
        MEM_READ  = 1'b0;
        MEM_WRITE = 1'b1;
        FUNCT3    = 3'b010;
        ADDR      = 32'h34;
        WDATA     = 32'hA5A5A5A5;
        REQ_VALID = 1'b1;
        RST       = 1'b1;
        @(posedge CLK);
        #1;
        REQ_VALID = 1'b0;
        RST       = 1'b0;
        chk("rst_accept_req_ready", REQ_READY, 1'b1);
        repeat (2) begin
            @(posedge CLK);
            #1;
            chk("rst_accept_rsp_valid", RSP_VALID, 1'b0);
        end
        model(1, 0, 3'b010, 32'h34, 0, mr, me);
        txn(1, 0, 3'b010, 32'h34, 0, 0, r, e, lat);
        chk("rst_accept_dropped", r, mr);

        // Random traffic against the model
        for (int i = 0; i < 200; i++) begin
            case ($urandom_range(0, 3))
                0: begin rd = 0; wr = 0; end
                1: begin rd = 0; wr = 1; end
                2: begin rd = 1; wr = 1; end
                default: begin rd = 1; wr = 0; end
            endcase
            if (wr) begin
                case ($urandom_range(0, 5))
                    0: f3 = 3'b000;
                    1: f3 = 3'b001;
                    2: f3 = 3'b010;
                    3: f3 = 3'b011;
                    4: f3 = 3'b110;
                    default: f3 = 3'b111;
                endcase
            end else begin
                f3 = 3'($urandom);
            end
            case ($urandom_range(0, 9))
                0: a = 32'h1000 + $urandom_range(0, 255);
                1: a = $urandom;
                default: a = $urandom_range(0, 63);
            endcase
            wd = $urandom;
            model(rd, wr, f3, a, wd, mr, me);
            txn(rd, wr, f3, a, wd, $urandom_range(0, 3) == 0 ? 2 : 0, r, e, lat);
            chk($sformatf("rnd%0d_rdata", i), r, mr);
            chk($sformatf("rnd%0d_error", i), e, me);
            chk($sformatf("rnd%0d_latency", i), lat, 2);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 The block SHALL have parameter DEPTH, default 1024, giving the number of 32-bit words in the internal data array.
REQ-002 The block SHALL have parameter AW, default 10, giving the word-index width; the requirement is DEPTH <= 2**AW.
REQ-003 Port CLK  in  1  single clock; all state updates on its rising edge.
REQ-004 Port RST  in  1  reset, synchronous and active-high.
REQ-005 Port REQ_VALID  in  1  initiator presents a request.
REQ-006 Port REQ_READY  out  1  responder can accept a request.
REQ-007 Port MEM_READ  in  1  read requested.
REQ-008 Port MEM_WRITE  in  1  write requested.
REQ-009 Port ADDR  in  32  byte address.
REQ-010 Port WDATA  in  32  store data; right-aligned.
REQ-011 Port FUNCT3  in  3  access size and sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-012 Port RSP_VALID  out  1  response available.
REQ-013 Port RSP_READY  in  1  initiator consumes the response.
REQ-014 Port RDATA  out  32  load result, extended to 32 bits.
REQ-015 Port ERROR  out  1  request rejected; no memory effect.

Function
REQ-016 The block SHALL implement an FSM with states IDLE, ACCESS and RESPOND.
REQ-017 REQ_READY SHALL be 1 only in IDLE.
REQ-018 A request SHALL be accepted on an edge where REQ_VALID and REQ_READY are both 1.
  - On acceptance, ADDR, WDATA, FUNCT3, MEM_READ and MEM_WRITE SHALL be captured.
  - On acceptance, the FSM SHALL go IDLE->ACCESS.
REQ-019 ACCESS SHALL last exactly one cycle, then go to RESPOND; the array read or write SHALL occur on the edge that leaves ACCESS.
REQ-020 In RESPOND, RSP_VALID SHALL be 1; RDATA and ERROR SHALL be stable until RSP_READY is 1.
  - RESPOND->IDLE SHALL occur on the edge where RSP_READY is 1.
  - Accept-to-RSP_VALID latency SHALL be 2 cycles.
  - Minimum request spacing SHALL be 3 cycles.
REQ-021 If MEM_WRITE=1, the request SHALL be a write regardless of MEM_READ; RDATA SHALL be 0 in the response.
REQ-022 If MEM_READ=1 and MEM_WRITE=0, the request SHALL be a read.
REQ-023 If both MEM_READ and MEM_WRITE are 0, the request SHALL still traverse ACCESS and RESPOND with no array access, RDATA=0 and ERROR=0.
REQ-024 Word index SHALL be ADDR[AW+1:2] and byte lane SHALL be ADDR[1:0].
REQ-025 Writes SHALL update only the addressed lanes; all other bytes SHALL be unchanged.
  - SB: WDATA[7:0] SHALL be written to lane ADDR[1:0].
  - SH: WDATA[15:0] SHALL be written to lanes {ADDR[1],0}+1:0.
  - SW: all four lanes SHALL be written.
REQ-026 Reads SHALL extract the addressed byte or halfword; B and H SHALL sign-extend, BU and HU SHALL zero-extend, and W SHALL return the full word.
REQ-027 ERROR SHALL be 1, with no array write and RDATA=0, if any of the following holds:
  - FUNCT3 is 011, 110 or 111 on a read or write;
  - H, HU or SH with ADDR[0]=1;
  - W with ADDR[1:0]!=0;
  - ADDR[31:2] >= DEPTH.
REQ-028 Input changes while not in IDLE SHALL have no effect.
REQ-029 REQ_VALID held high across responses SHALL be accepted again only after the return to IDLE.

Reset
REQ-030 When RST=1 at an edge, the FSM SHALL enter IDLE regardless of the current state. In the following cycle:
  - RSP_VALID SHALL be 0;
  - RDATA SHALL be 0;
  - ERROR SHALL be 0;
  - REQ_READY SHALL be 1.
REQ-031 RST at the edge leaving ACCESS SHALL suppress the pending write; array contents SHALL otherwise not be reset.
REQ-032 RST SHALL take priority over a simultaneous acceptance; that request SHALL be dropped.

Verification
REQ-033 The bench SHALL cover these directed scenarios:
  - SW 0xDEADBEEF to 0x10, then LW 0x10 -> RDATA=0xDEADBEEF, ERROR=0, RSP_VALID 2 cycles after accept.
  - SB 0x80 to 0x11, then LB 0x11 -> 0xFFFFFF80; LBU 0x11 -> 0x00000080; LW 0x10 -> 0xDEAD80EF.
  - LH 0x13 -> ERROR=1, RDATA=0; SW 0x12 -> ERROR=1 and word 0x10 unchanged.
  - MEM_READ=1, MEM_WRITE=1, SW 0x12345678 to 0x20 -> write performed, RDATA=0; LW 0x20 -> 0x12345678.
  - RSP_READY held 0 for 5 cycles -> RSP_VALID, RDATA and ERROR stable, REQ_READY=0; a new REQ_VALID is not accepted.
  - RST asserted during ACCESS of SW 0xFFFFFFFF to 0x30 -> next cycle REQ_READY=1, RSP_VALID=0; LW 0x30 returns the prior value.
